// File: rtl/wb_master.sv
// Wishbone classic single-transfer master: one client request per bus cycle,
// with an ACK timeout and a release state that absorbs a slave's lingering ACK.
module wb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    output logic                    ready_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    CYC_O,
    output logic                    STB_O,
    output logic                    WE_O,
    output logic [ADDR_WIDTH-1:0]   ADR_O,
    output logic [DATA_WIDTH-1:0]   DAT_O,
    output logic [DATA_WIDTH/8-1:0] SEL_O,
    input  logic [DATA_WIDTH-1:0]   DAT_I,
    input  logic                    ACK_I
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;

    typedef struct packed {
        logic                    we;
        logic [ADDR_WIDTH-1:0]   adr;
        logic [DATA_WIDTH-1:0]   dat;
        logic [DATA_WIDTH/8-1:0] sel;
    } wb_req_t;

    state_t            state_q, state_d;
    wb_req_t           req_q;
    logic              cyc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              timeout;

    assign timeout = (cnt_q == CNT_LAST);
    assign ready_o = (state_q == IDLE);

    assign CYC_O = cyc_q;
    assign STB_O = cyc_q;
    assign WE_O  = req_q.we;
    assign ADR_O = req_q.adr;
    assign DAT_O = req_q.dat;
    assign SEL_O = req_q.sel;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_i) state_d = ACTIVE;
            ACTIVE:  if (ACK_I || timeout) state_d = RELEASE;
            RELEASE: if (!ACK_I) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ACK is checked before the timeout so a last-cycle ACK still counts as success
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q   <= '0;
            cyc_q   <= 1'b0;
            cnt_q   <= '0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state_q)
                IDLE: if (req_i) begin
                    req_q <= '{we: we_i, adr: addr_i, dat: wdata_i, sel: sel_i};
                    cyc_q <= 1'b1;
                    cnt_q <= '0;
                end
                ACTIVE: begin
                    if (ACK_I) begin
                        cyc_q  <= 1'b0;
                        done_o <= 1'b1;
                        if (!req_q.we) rdata_o <= DAT_I;
                    end else if (timeout) begin
                        cyc_q  <= 1'b0;
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master.sv
// Randomized self-checking bench for wb_master; expectations come from a
// transaction-level model (ACK cycle vs. timeout limit, last good read data).
module tb_wb_master;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0, we_i = 1'b0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic [3:0]  sel_i = '0;
    logic        ready_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic        CYC_O, STB_O, WE_O;
    logic [31:0] ADR_O, DAT_O;
    logic [3:0]  SEL_O;
    logic [31:0] DAT_I = '0;
    logic        ACK_I = 1'b0;

    int          vecs = 0;
    int          errs = 0;
    logic [31:0] exp_rdata = '0;

    wb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .sel_i(sel_i), .ready_o(ready_o), .done_o(done_o),
        .err_o(err_o), .rdata_o(rdata_o), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .DAT_I(DAT_I), .ACK_I(ACK_I)
    );

    always #5 clk_i = ~clk_i;

    // One client transfer served by a bench slave that ACKs on ACTIVE cycle
    // ack_cycle (0 = never) and then holds ACK for 'hold' further cycles.
    task automatic do_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] sel, input int ack_cycle, input logic [31:0] dat,
                           input int hold, input bit hreq);
        int n;
        bit got;
        bit exp_err;
        int exp_n;
        int hold_eff;
        exp_err  = !(ack_cycle >= 1 && ack_cycle <= TMO);
        exp_n    = exp_err ? TMO : ack_cycle;
        hold_eff = exp_err ? 0 : hold;
        @(negedge clk_i);
        vecs++;
        if (ready_o !== 1'b1) begin
            errs++; $display("FAIL ready_before_req: got %b want 1", ready_o);
        end
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; sel_i = sel;
        @(negedge clk_i);
        req_i = 1'b0; we_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom;
        sel_i = 4'($urandom);
        n = 0; got = 1'b0;
        while (!got && n <= TMO + 4) begin
            if (done_o === 1'b1) got = 1'b1;
            else begin
                n++;
                vecs++;
                if ({CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O, ready_o} !==
                    {2'b11, we, addr, wdata, sel, 1'b0}) begin
                    errs++;
                    $display("FAIL bus_active cyc%0d: got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h rdy=%b want 1 1 %b %h %h %h 0",
                             n, CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O, ready_o, we, addr, wdata, sel);
                end
                if (n == ack_cycle) begin ACK_I = 1'b1; DAT_I = dat; end
                @(negedge clk_i);
            end
        end
        vecs++;
        if (!got || n != exp_n) begin
            errs++; $display("FAIL active_cycles: got done=%b after %0d cycles want %0d", got, n, exp_n);
        end
        if (got) begin
            if (!exp_err && !we) exp_rdata = dat;
            vecs++;
            if ({err_o, CYC_O, STB_O, ready_o} !== {exp_err, 3'b000}) begin
                errs++; $display("FAIL done_flags: got err=%b cyc=%b stb=%b rdy=%b want err=%b 0 0 0",
                                 err_o, CYC_O, STB_O, ready_o, exp_err);
            end
            vecs++;
            if (rdata_o !== exp_rdata) begin
                errs++; $display("FAIL rdata: got %h want %h", rdata_o, exp_rdata);
            end
        end
        for (int h = 0; h < hold_eff; h++) begin
            DAT_I = $urandom;
            if (hreq) begin req_i = 1'b1; we_i = 1'b0; addr_i = addr + 32'd4; wdata_i = '0; sel_i = 4'hF; end
            @(negedge clk_i);
            vecs++;
            if ({done_o, err_o, CYC_O, ready_o, rdata_o} !== {4'b0000, exp_rdata}) begin
                errs++; $display("FAIL release_hold%0d: got done=%b err=%b cyc=%b rdy=%b rdata=%h want 0 0 0 0 %h",
                                 h, done_o, err_o, CYC_O, ready_o, rdata_o, exp_rdata);
            end
        end
        ACK_I = 1'b0;
        @(negedge clk_i);
        vecs++;
        if ({ready_o, done_o, err_o, CYC_O} !== 4'b1000) begin
            errs++; $display("FAIL back_to_idle: got rdy=%b done=%b err=%b cyc=%b want 1 0 0 0",
                             ready_o, done_o, err_o, CYC_O);
        end
    endtask

    task automatic test_reset;
        #1;
        vecs++;
        if ({CYC_O, STB_O, WE_O, done_o, err_o, ADR_O, DAT_O, SEL_O, rdata_o} !== '0) begin
            errs++; $display("FAIL reset_outputs: got cyc=%b stb=%b we=%b done=%b err=%b adr=%h dat=%h sel=%h rdata=%h want all 0",
                             CYC_O, STB_O, WE_O, done_o, err_o, ADR_O, DAT_O, SEL_O, rdata_o);
        end
        vecs++;
        if (ready_o !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        vecs++;
        if ({ready_o, CYC_O, done_o} !== 3'b100) begin
            errs++; $display("FAIL idle_no_req: got rdy=%b cyc=%b done=%b want 1 0 0", ready_o, CYC_O, done_o);
        end
    endtask

    task automatic test_read;
        do_xfer(1'b0, 32'h10, 32'h0, 4'hF, 3, 32'hDEADBEEF, 0, 1'b0);
    endtask

    task automatic test_write;
        do_xfer(1'b1, 32'h20, 32'h12345678, 4'h3, 2, 32'hCAFEF00D, 0, 1'b0);
    endtask

    task automatic test_timeout;
        do_xfer(1'b0, 32'h44, 32'h0, 4'hF, 0, 32'h0, 0, 1'b0);
    endtask

    task automatic test_ack_on_timeout;
        do_xfer(1'b0, 32'h48, 32'h0, 4'hF, TMO, 32'hA5A55A5A, 0, 1'b0);
    endtask

    task automatic test_held_ack;
        logic [31:0] d;
        do_xfer(1'b0, 32'h30, 32'h0, 4'hF, 1, 32'h0BADC0DE, 2, 1'b1);
        @(negedge clk_i);
        vecs++;
        if ({CYC_O, STB_O, ADR_O, ready_o} !== {2'b11, 32'h34, 1'b0}) begin
            errs++; $display("FAIL held_req_accept: got cyc=%b stb=%b adr=%h rdy=%b want 1 1 00000034 0",
                             CYC_O, STB_O, ADR_O, ready_o);
        end
        req_i = 1'b0;
        d = $urandom;
        ACK_I = 1'b1; DAT_I = d;
        @(negedge clk_i);
        ACK_I = 1'b0;
        exp_rdata = d;
        vecs++;
        if ({done_o, err_o, rdata_o} !== {2'b10, exp_rdata}) begin
            errs++; $display("FAIL held_req_done: got done=%b err=%b rdata=%h want 1 0 %h",
                             done_o, err_o, rdata_o, exp_rdata);
        end
        @(negedge clk_i);
        vecs++;
        if ({done_o, ready_o} !== 2'b01) begin
            errs++; $display("FAIL held_req_idle: got done=%b rdy=%b want 0 1", done_o, ready_o);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h50; sel_i = 4'hF;
        @(negedge clk_i);
        req_i = 1'b0;
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        exp_rdata = '0;
        vecs++;
        if ({CYC_O, STB_O, done_o, err_o, ready_o, rdata_o} !== {5'b00001, exp_rdata}) begin
            errs++; $display("FAIL async_reset: got cyc=%b stb=%b done=%b err=%b rdy=%b rdata=%h want 0 0 0 0 1 %h",
                             CYC_O, STB_O, done_o, err_o, ready_o, rdata_o, exp_rdata);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            vecs++;
            if ({done_o, CYC_O} !== 2'b00) begin
                errs++; $display("FAIL post_reset_quiet%0d: got done=%b cyc=%b want 0 0", i, done_o, CYC_O);
            end
        end
        do_xfer(1'b0, 32'h54, 32'h0, 4'hF, 2, 32'h13579BDF, 0, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            do_xfer(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 6)),
                    $urandom, int'($urandom_range(0, 2)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_ack_on_timeout();
        test_held_ack();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
